// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: arbitrates a single-port character RAM between video refresh, terminal writes and a fill engine
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   video_req, video_addr, video_data  video read port; video owns the RAM whenever video_req=1
//   wr_valid, wr_ready, wr_addr, wr_data
//                                      single-character write handshake
//   fill_start, fill_addr, fill_count, fill_char, fill_busy, fill_done
//                                      fill (clear) command and status
//   ram_addr, ram_we, ram_wdata, ram_rdata
//                                      single-port RAM with 1-cycle read latency
// Build option: define CHAR_BUFFER_FILL_EN to include the fill engine; without it the fill
// inputs are ignored, fill_busy/fill_done stay low and the controller is always idle.
module char_buffer_ctrl #(
  parameter int ADDR_BITS   = 11,
  parameter int BUFFER_SIZE = 1920
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 video_req,
  input  logic [ADDR_BITS-1:0] video_addr,
  output logic [7:0]           video_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 fill_start,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [ADDR_BITS-1:0] fill_count,
  input  logic [7:0]           fill_char,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);
  // one extra bit so BUFFER_SIZE == 2**ADDR_BITS still compares correctly
  localparam logic [ADDR_BITS:0] SIZE = (ADDR_BITS+1)'(BUFFER_SIZE);
  logic                 wr_ok;
  logic                 fill_wr;
  logic [ADDR_BITS-1:0] fill_waddr;
  logic [7:0]           fill_wdata;
`ifdef CHAR_BUFFER_FILL_EN
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(BUFFER_SIZE - 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cur_q, cur_d;
  logic [ADDR_BITS-1:0] rem_q, rem_d;
  logic [7:0]           char_q, char_d;
  logic                 done_q, done_d;
  // done is registered: it rises together with remaining reaching zero, so it
  // coincides with the last FILL cycle and the FSM leaves FILL right after it
  always_comb begin
    fill_wr = (state_q == FILL) && !video_req && (rem_q != '0);
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    char_d  = char_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (fill_start) begin
        state_d = FILL;
        cur_d   = ({1'b0, fill_addr} < SIZE) ? fill_addr : '0;
        rem_d   = fill_count;
        char_d  = fill_char;
        done_d  = (fill_count == '0);
      end
    end else if (rem_q == '0) begin
      state_d = IDLE;
    end else if (fill_wr) begin
      rem_d  = rem_q - ADDR_BITS'(1);
      cur_d  = (cur_q == LAST) ? '0 : cur_q + ADDR_BITS'(1);
      done_d = (rem_q == ADDR_BITS'(1));
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      char_q  <= char_d;
      done_q  <= done_d;
    end
  end
  assign wr_ready   = (state_q == IDLE) && !video_req;
  assign fill_busy  = (state_q == FILL);
  assign fill_done  = done_q;
  assign fill_waddr = cur_q;
  assign fill_wdata = char_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_start, fill_addr, fill_count, fill_char};
  assign fill_wr     = 1'b0;
  assign wr_ready    = !video_req;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign fill_waddr  = '0;
  assign fill_wdata  = '0;
`endif
  // out-of-range writes are acknowledged but never reach the RAM; the reset
  // gate keeps the RAM quiet while reset_n is low
  always_comb begin
    wr_ok      = reset_n && wr_valid && wr_ready && ({1'b0, wr_addr} < SIZE);
    ram_we     = fill_wr || wr_ok;
    ram_addr   = fill_wr ? fill_waddr : wr_ok ? wr_addr : video_addr;
    ram_wdata  = fill_wr ? fill_wdata : wr_data;
    video_data = ram_rdata;
  end
endmodule

// File: tb/tb_char_buffer_ctrl.sv
// tb_char_buffer_ctrl: scoreboard bench for char_buffer_ctrl with a behavioural RAM and reference memory
module tb_char_buffer_ctrl;
  localparam int AW = 11;
  localparam int BS = 1920;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          video_req = 1'b0;
  logic [AW-1:0] video_addr = '0;
  logic [7:0]    video_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_addr = '0;
  logic [AW-1:0] fill_count = '0;
  logic [7:0]    fill_char = '0;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic          mem_init = 1'b1;
  always #5 clk = ~clk;
  char_buffer_ctrl #(.ADDR_BITS(AW), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .reset_n(reset_n),
    .video_req(video_req), .video_addr(video_addr), .video_data(video_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_count(fill_count), .fill_char(fill_char),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  logic [7:0] ram [2048];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 2048; i++) ram[i] <= 8'(i * 7);
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end
  typedef struct {logic [AW-1:0] a; logic [7:0] d;} wr_t;
  wr_t        exp_wr_q[$];
  int         exp_fill_q[$];
  int         exp_done = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [2048];
  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction
  wr_t           w;
  logic          prev_rd = 1'b0;
  logic          prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            busy_run = 0;
  int            done_at = -1;
  int            n_done = 0;
  always @(negedge clk) begin
    if (mem_init) for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i * 7);
    if (!reset_n) begin
      check("reset_ram_we", ram_we, 0);
      check("reset_fill_busy", fill_busy, 0);
      check("reset_fill_done", fill_done, 0);
      prev_rd = 1'b0; prev_busy = 1'b0; busy_run = 0; done_at = -1;
    end else begin
      if (prev_rd) check("video_data", video_data, ref_mem[prev_addr]);
      if (video_req) begin
        check("video_ram_addr", ram_addr, video_addr);
        check("video_ram_we", ram_we, 0);
        check("video_wr_ready", wr_ready, 0);
      end else if (!fill_busy) check("idle_wr_ready", wr_ready, 1);
      if (!ram_we) check("noop_ram_addr", ram_addr, video_addr);
      else if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected at %0t", ram_addr, ram_wdata, $time);
      end else begin
        w = exp_wr_q.pop_front();
        check("write_addr", ram_addr, w.a);
        check("write_data", ram_wdata, w.d);
        ref_mem[w.a] = w.d;
      end
      prev_rd = !ram_we;
      prev_addr = ram_addr;
      if (fill_busy) busy_run++;
      if (fill_done) begin
        n_done++;
        done_at = busy_run;
        check("done_while_busy", fill_busy, 1);
      end
      if (prev_busy && !fill_busy) begin
        if (exp_fill_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fill: busy for %0d cycles, no fill expected", busy_run);
        end else check("busy_cycles", busy_run, exp_fill_q.pop_front());
        check("done_on_last_busy_cycle", done_at, busy_run);
        busy_run = 0; done_at = -1;
      end
      prev_busy = fill_busy;
    end
  end
  task automatic idle();
    @(posedge clk) #1;
    video_req = 1'b0; wr_valid = 1'b0; fill_start = 1'b0;
  endtask
  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk) #1;
      video_req = 1'b1; video_addr = AW'($urandom); wr_valid = 1'b1; wr_addr = a; wr_data = d;
    end
    @(posedge clk) #1;
    video_req = 1'b0; wr_valid = 1'b1; wr_addr = a; wr_data = d;
    if (int'(a) < BS) exp_wr_q.push_back('{a: a, d: d});
    idle();
  endtask
  task automatic do_read(input logic [AW-1:0] a);
    @(posedge clk) #1;
    video_req = 1'b1; video_addr = a; wr_valid = 1'b0;
    idle();
  endtask
  // pat bit i is video_req during the i-th cycle after the start cycle
  task automatic do_fill(input logic [AW-1:0] fa, input logic [AW-1:0] fc, input logic [7:0] ch,
                         input logic ww, input logic [AW-1:0] wa, input logic [7:0] wd, input logic [63:0] pat);
    int a0, run, z;
    a0 = (int'(fa) >= BS) ? 0 : int'(fa);
    @(posedge clk) #1;
    video_req = 1'b0; fill_start = 1'b1; fill_addr = fa; fill_count = fc; fill_char = ch;
    wr_valid = ww; wr_addr = wa; wr_data = wd;
    if (ww && int'(wa) < BS) exp_wr_q.push_back('{a: wa, d: wd});
`ifdef CHAR_BUFFER_FILL_EN
    for (int i = 0; i < int'(fc); i++) exp_wr_q.push_back('{a: AW'((a0 + i) % BS), d: ch});
    z = 0; run = 0;
    for (int i = 0; run == 0; i++) begin
      if (z == int'(fc)) run = i + 1;
      else if (!(i < 64 && pat[i])) z++;
    end
    exp_fill_q.push_back(run);
    exp_done++;
    for (int i = 0; i < run; i++) begin
      @(posedge clk) #1;
      fill_start = 1'($urandom); fill_addr = AW'($urandom); fill_count = AW'($urandom);
      video_req = (i < 64) ? pat[i] : 1'b0; video_addr = AW'($urandom);
      wr_valid = 1'b1; wr_addr = AW'($urandom_range(0, BS - 1)); wr_data = 8'($urandom);
    end
`else
    z = a0 + int'(pat[0]); run = z;
    repeat (6) begin
      @(posedge clk) #1;
      fill_start = 1'b0; video_req = 1'($urandom); video_addr = AW'($urandom); wr_valid = 1'b0;
    end
    @(negedge clk);
    check("nofill_busy", fill_busy, 0);
`endif
    idle();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(posedge clk) #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_wr_ready", wr_ready, 1);
    check("post_reset_fill_busy", fill_busy, 0);
    check("post_reset_ram_we", ram_we, 0);
    @(posedge clk) #1;
    video_req = 1'b1; video_addr = 5; wr_valid = 1'b1; wr_addr = 7; wr_data = 8'h55;
    @(negedge clk);
    check("prio_ram_addr", ram_addr, 5);
    check("prio_ram_we", ram_we, 0);
    check("prio_wr_ready", wr_ready, 0);
    @(posedge clk) #1;
    video_req = 1'b0;
    exp_wr_q.push_back('{a: 7, d: 8'h55});
    @(negedge clk);
    check("prio_release_we", ram_we, 1);
    check("prio_release_addr", ram_addr, 7);
    idle();
    do_write(100, 8'h41, 0);
    @(posedge clk) #1;
    video_req = 1'b1; video_addr = 100;
    @(posedge clk) #1;
    video_req = 1'b0;
    @(negedge clk);
    check("readback_100", video_data, 8'h41);
    @(posedge clk) #1;
    video_req = 1'b0; wr_valid = 1'b1; wr_addr = 1920; wr_data = 8'hFF;
    @(negedge clk);
    check("oor_wr_ready", wr_ready, 1);
    check("oor_ram_we", ram_we, 0);
    idle();
`ifdef CHAR_BUFFER_FILL_EN
    do_fill(1918, 4, 8'h20, 1'b0, 0, 0, 64'h0);
    do_fill(300, 3, 8'h2D, 1'b0, 0, 0, 64'h0D);
    do_fill(50, 0, 8'h11, 1'b1, 60, 8'h99, 64'h0);
    do_fill(2000, 2, 8'h33, 1'b0, 0, 0, 64'h1);
    @(posedge clk) #1;
    video_req = 1'b0; wr_valid = 1'b0; fill_start = 1'b1; fill_addr = 200; fill_count = 80; fill_char = 8'h2E;
    for (int i = 0; i < 80; i++) exp_wr_q.push_back('{a: AW'(200 + i), d: 8'h2E});
    repeat (10) begin
      @(posedge clk) #1;
      fill_start = 1'b0; video_req = 1'b0;
    end
    @(posedge clk) #1;
    reset_n = 1'b0;
    #1;
    check("abort_fill_busy", fill_busy, 0);
    check("abort_fill_done", fill_done, 0);
    check("abort_writes_done", 80 - exp_wr_q.size(), 10);
    exp_wr_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    do_read(209);
    @(negedge clk);
    check("abort_cell_10", video_data, 8'h2E);
    do_read(210);
    @(negedge clk);
    check("abort_cell_11", video_data, 8'(210 * 7));
`else
    do_fill(10, 5, 8'h20, 1'b0, 0, 0, 64'h0);
    do_fill(1918, 4, 8'h20, 1'b1, 400, 8'h77, 64'h0);
    do_read(10);
    @(negedge clk);
    check("nofill_cell_10", video_data, 8'(10 * 7));
`endif
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: do_write(AW'($urandom_range(0, 1999)), 8'($urandom), $urandom_range(0, 2));
        1: do_read(AW'($urandom_range(0, 2047)));
        default: do_fill(AW'($urandom_range(0, 2000)), AW'($urandom_range(0, 20)), 8'($urandom),
                         1'($urandom), AW'($urandom_range(0, 1999)), 8'($urandom),
                         {$urandom, $urandom} & {$urandom, $urandom});
      endcase
    end
    repeat (3) idle();
    @(negedge clk);
    check("pending_writes", exp_wr_q.size(), 0);
    check("pending_fills", exp_fill_q.size(), 0);
    check("done_pulses", n_done, exp_done);
    check("final_fill_busy", fill_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/char_buffer_ctrl.md
CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 11, char buffer address width.
REQ-002 SHALL have parameter BUFFER_SIZE, default 1920 (24x80), number of valid char cells.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port video_req  input  1  video generator owns RAM this cycle (high outside blanking).
REQ-006 SHALL have port video_addr  input  ADDR_BITS  video read address.
REQ-007 SHALL have port video_data  output  8  read data to video generator.
REQ-008 SHALL have ports wr_valid input 1, wr_ready output 1, wr_addr input ADDR_BITS, wr_data input 8: terminal single-char write channel.
REQ-009 SHALL have ports fill_start input 1, fill_addr input ADDR_BITS, fill_count input ADDR_BITS, fill_char input 8: fill (clear) command.
REQ-010 SHALL have ports fill_busy output 1 and fill_done output 1 (one-cycle pulse).
REQ-011 SHALL have ports ram_addr output ADDR_BITS, ram_we output 1, ram_wdata output 8, ram_rdata input 8 (single-port RAM, 1-cycle read latency).

Function
REQ-012 SHALL drive ram_addr/ram_we/ram_wdata combinationally from current inputs and registered state (zero added latency on video path).
REQ-013 SHALL give video absolute priority: video_req=1 -> ram_addr=video_addr, ram_we=0, wr_ready=0, fill stalls.
REQ-014 SHALL pass video_data = ram_rdata, valid the cycle after video_addr is presented.
REQ-015 SHALL use FSM states IDLE and FILL.
REQ-016 SHALL set wr_ready = (state==IDLE) && !video_req; transfer occurs when wr_valid && wr_ready.
REQ-017 SHALL on transfer drive ram_addr=wr_addr, ram_wdata=wr_data, ram_we=1 same cycle, unless wr_addr >= BUFFER_SIZE, then ram_we=0 (write dropped, still acknowledged).
REQ-018 SHALL in IDLE on fill_start=1 latch cur=fill_addr, remaining=fill_count, char=fill_char and enter FILL next cycle; a write transferred in the same cycle completes normally.
REQ-019 SHALL ignore fill_start while in FILL.
REQ-020 SHALL in FILL, each cycle with video_req=0 and remaining!=0, write char at cur, decrement remaining, advance cur with wrap BUFFER_SIZE-1 -> 0.
REQ-021 SHALL when remaining==0 in FILL pulse fill_done one cycle and return to IDLE the next cycle; fill_count=0 yields no writes and fill_done one cycle after entering FILL.
REQ-022 SHALL hold fill_busy=1 exactly while state==FILL.
REQ-023 SHALL, if fill_addr >= BUFFER_SIZE, load cur=0.
REQ-024 SHALL ram_we=0 whenever no write transfer or fill write occurs; ram_addr then = video_addr.

Reset
REQ-025 SHALL on reset_n=0 asynchronously force state=IDLE, fill_busy=0, fill_done=0, remaining=0, cur=0.
REQ-026 SHALL abort an in-progress fill on reset without fill_done; cells already written stay written.
REQ-027 SHALL keep ram_we=0 while reset_n=0.

Configuration
REQ-028 SHALL compile the fill engine only when macro CHAR_BUFFER_FILL_EN is defined.
REQ-029 SHALL without CHAR_BUFFER_FILL_EN keep all fill ports, ignore fill inputs, tie fill_busy=0 and fill_done=0, state permanently IDLE.

Verification
REQ-030 SHALL test video priority: video_req=1, video_addr=5, wr_valid=1 wr_addr=7 -> ram_addr=5, ram_we=0, wr_ready=0; drop video_req -> write of 7 same cycle.
REQ-031 SHALL test write: wr_addr=100, wr_data=0x41, video_req=0 -> ram_we=1 one cycle, readback of 100 returns 0x41 next cycle.
REQ-032 SHALL test wrap fill: fill_addr=1918, fill_count=4, fill_char=0x20 -> writes 1918,1919,0,1 then fill_done one pulse, fill_busy high 5 cycles.
REQ-033 SHALL test stall: fill_count=3 with video_req toggling 1,0,1,1,0,0 -> exactly 3 writes, only in video_req=0 cycles, ram_addr=video_addr otherwise.
REQ-034 SHALL test reset mid-fill: fill_count=80, reset_n low after 10 writes -> fill_busy=0 immediately, no fill_done, 11th cell untouched.
REQ-035 SHALL test out-of-range write wr_addr=1920 -> wr_ready=1, ram_we=0; without CHAR_BUFFER_FILL_EN fill_start -> no writes, fill_busy=0.
